// File: rtl/and_share_arbiter.sv
// and_share_arbiter
//
// Round-robin scheduler that shares a single fixed-latency AND unit
// (result = a & b) between N_REQ requesters. One request is granted at a
// time. The granted requester's operands are reduced to their AND at the
// grant edge. The result is returned LAT cycles after the grant cycle,
// tagged with the requester index.
//
// Parameters
//   N_REQ  number of requesters (2..8)
//   WIDTH  operand/result width
//   LAT    unit latency in clock cycles (1..255)
//   IDW    result id width, clog2(N_REQ)
//
// Ports
//   clock      rising-edge clock
//   reset_n    asynchronous active-low reset
//   req        per-requester request level
//   a, b       packed operands, requester i at [i*WIDTH +: WIDTH]
//   gnt        one-hot grant pulse, high for the single ISSUE cycle
//   busy       high while an operation is in flight (ISSUE/WAIT/DONE)
//   res_valid  one-cycle result pulse (DONE)
//   res_data   AND result, held until the next DONE
//   res_id     index of the requester that produced res_data
module and_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int LAT   = 10,
  parameter int IDW   = 2
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] a,
  input  logic [N_REQ*WIDTH-1:0] b,
  output logic [N_REQ-1:0]       gnt,
  output logic                   busy,
  output logic                   res_valid,
  output logic [WIDTH-1:0]       res_data,
  output logic [IDW-1:0]         res_id
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // The counter is loaded with LAT-1 at the grant edge; ISSUE and WAIT
  // together then last exactly LAT cycles before DONE.
  localparam logic [7:0]     CNT_LOAD = 8'(LAT - 1);
  localparam logic [IDW-1:0] ID_LAST  = IDW'(N_REQ - 1);

  logic [1:0]       state;
  logic [7:0]       cnt;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   cur_id;
  logic [WIDTH-1:0] cur_res;

  logic [IDW-1:0]   base;
  logic [IDW-1:0]   scan_idx;
  logic [IDW-1:0]   win_id;
  logic             win_found;
  logic [WIDTH-1:0] win_res;

  // Explicit wrap so non-power-of-two N_REQ never indexes a missing requester.
  function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] v);
    return (v == ID_LAST) ? '0 : v + IDW'(1);
  endfunction

  // In DONE the pointer is being moved past the finishing requester on this
  // very edge, so the search must already start from that new position.
  assign base = (state == S_DONE) ? wrap_inc(cur_id) : ptr;

  // Round-robin search: first asserted req at base, base+1, ... (mod N_REQ).
  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    win_found = 1'b0;
    win_id    = '0;
    scan_idx  = base;
    for (int k = 0; k < N_REQ; k++) begin
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win_id    = scan_idx;
      end
      scan_idx = wrap_inc(scan_idx);
    end
  end

  // Only the AND of the winner's operands is kept; the operands themselves
  // are never stored, so later changes on a/b cannot affect the result.
  assign win_res = a[win_id*WIDTH +: WIDTH] & b[win_id*WIDTH +: WIDTH];

  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: state registers use non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    if (!reset_n) begin
      state    <= S_IDLE;
      cnt      <= 8'd0;
      ptr      <= '0;
      cur_id   <= '0;
      cur_res  <= '0;
      res_data <= '0;
      res_id   <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (state == S_DONE) ptr <= wrap_inc(cur_id);
          if (win_found) begin
            state   <= S_ISSUE;
            cur_id  <= win_id;
            cur_res <= win_res;
            cnt     <= CNT_LOAD;
          end else begin
            state <= S_IDLE;
          end
        end
        S_ISSUE: begin
          if (cnt == 8'd0) begin
            state    <= S_DONE;
            res_data <= cur_res;
            res_id   <= cur_id;
          end else begin
            state <= S_WAIT;
            cnt   <= cnt - 8'd1;
          end
        end
        S_WAIT: begin
          if (cnt == 8'd0) begin
            state    <= S_DONE;
            res_data <= cur_res;
            res_id   <= cur_id;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode straight from the state register, so an asynchronous
  // reset clears them immediately and aborts any operation in flight.
  always_comb begin
    gnt = '0;
    if (state == S_ISSUE) gnt[cur_id] = 1'b1;
  end

  assign busy      = (state != S_IDLE);
  assign res_valid = (state == S_DONE);

endmodule

// File: tb/tb_and_share_arbiter.sv
// Self-checking bench for and_share_arbiter.
// Main instance: N_REQ=4, WIDTH=8, LAT=10, compared every cycle against a
// behavioural model (operation age counted from the grant cycle).
// Second instance: LAT=1 corner case.
module tb_and_share_arbiter;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int LAT = 10;
  localparam int IDW = 2;

  logic           clock = 1'b0;
  logic           reset_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] a, b;
  logic [N-1:0]   gnt;
  logic           busy, res_valid;
  logic [W-1:0]   res_data;
  logic [IDW-1:0] res_id;

  logic [N-1:0]   req1;
  logic [N*W-1:0] a1, b1;
  logic [N-1:0]   gnt1;
  logic           busy1, rv1;
  logic [W-1:0]   rd1;
  logic [IDW-1:0] rid1;

  always #5 clock = ~clock;

  and_share_arbiter #(.N_REQ(N), .WIDTH(W), .LAT(LAT), .IDW(IDW)) u_dut (
    .clock(clock), .reset_n(reset_n), .req(req), .a(a), .b(b),
    .gnt(gnt), .busy(busy), .res_valid(res_valid),
    .res_data(res_data), .res_id(res_id));

  and_share_arbiter #(.N_REQ(N), .WIDTH(W), .LAT(1), .IDW(IDW)) u_lat1 (
    .clock(clock), .reset_n(reset_n), .req(req1), .a(a1), .b(b1),
    .gnt(gnt1), .busy(busy1), .res_valid(rv1),
    .res_data(rd1), .res_id(rid1));

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // An operation is "active" from its grant cycle (age 0) through its
  // result cycle (age LAT). Arbitration happens whenever nothing is active
  // or the active operation is in its result cycle.
  bit             m_active;
  int             m_age;
  logic [IDW-1:0] m_id, m_ptr, m_out_id;
  logic [W-1:0]   m_res, m_out_data;
  int             m_base, m_win;

  always_comb begin
    m_base = m_active ? (int'(m_id) + 1) % N : int'(m_ptr);
    m_win  = -1;
    for (int k = N - 1; k >= 0; k--)
      if (req[(m_base + k) % N]) m_win = (m_base + k) % N;
  end

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_active   <= 1'b0;
      m_age      <= 0;
      m_id       <= '0;
      m_ptr      <= '0;
      m_res      <= '0;
      m_out_data <= '0;
      m_out_id   <= '0;
    end else if (m_active && m_age < LAT) begin
      m_age <= m_age + 1;
      if (m_age == LAT - 1) begin
        m_out_data <= m_res;
        m_out_id   <= m_id;
      end
    end else begin
      if (m_active) m_ptr <= IDW'(m_base);
      if (m_win >= 0) begin
        m_active <= 1'b1;
        m_age    <= 0;
        m_id     <= IDW'(m_win);
        m_res    <= a[m_win*W +: W] & b[m_win*W +: W];
      end else begin
        m_active <= 1'b0;
      end
    end
  end

  logic [N-1:0] e_gnt;
  logic         e_busy, e_rv;
  always_comb begin
    e_gnt = '0;
    if (m_active && m_age == 0) e_gnt[m_id] = 1'b1;
    e_busy = m_active;
    e_rv   = m_active && (m_age == LAT);
  end

  always @(negedge clock)
    check("cycle model {gnt,busy,rv,data,id}",
          {16'h0, gnt, busy, res_valid, res_data, res_id},
          {16'h0, e_gnt, e_busy, e_rv, m_out_data, m_out_id});

  // ---------------- helpers ----------------
  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    req     = '0;
    req1    = '0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic wait_gnt(input string name, output logic [N-1:0] g);
    g = '0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clock);
      if (gnt != '0) begin
        g = gnt;
        return;
      end
    end
    check({name, " grant timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input string name);
    for (int c = 0; c < 100; c++) begin
      @(negedge clock);
      if (!busy) return;
    end
    check({name, " idle timeout"}, 32'd0, 32'd1);
  endtask

  typedef struct {
    int         idx;
    logic [7:0] av;
    logic [7:0] bv;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[5];

  initial begin
    logic [N-1:0] g;
    int           lat_cnt, busy_cnt, g1_seen, n_g1;
    bit           found;

    reset_n = 1'b0;
    req = '0; a = '0; b = '0;
    req1 = '0; a1 = 32'h0000_00FF; b1 = 32'h0000_00AA;
    repeat (3) @(negedge clock);
    check("reset gnt/busy/rv/data/id", {16'h0, gnt, busy, res_valid, res_data, res_id}, 32'h0);
    reset_n = 1'b1;

    // ---- LAT=1: gnt and res_valid alternate, busy stays high ----
    @(negedge clock);
    req1  = 4'b0001;
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (gnt1 != '0) begin
        found = 1'b1;
        break;
      end
    end
    check("lat1 grant seen", 32'(found), 32'd1);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clock);
      check("lat1 {gnt,busy,rv}", 32'({gnt1, busy1, rv1}),
            (k % 2 == 0) ? 32'b0001_1_0 : 32'b0000_1_1);
      if (k % 2 == 1) check("lat1 res_data", 32'(rd1), 32'h0000_00AA);
    end
    req1 = '0;

    // ---- table: single requests, latency, busy length, hold ----
    tbl[0] = '{2, 8'hF0, 8'h3C, 8'h30};
    tbl[1] = '{0, 8'hFF, 8'hAA, 8'hAA};
    tbl[2] = '{1, 8'h0F, 8'hF5, 8'h05};
    tbl[3] = '{3, 8'h81, 8'h7E, 8'h00};
    tbl[4] = '{3, 8'hC3, 8'hE7, 8'hC3};
    wait_idle("pre-table");
    for (int t = 0; t < 5; t++) begin
      a = $urandom;
      b = $urandom;
      a[tbl[t].idx*W +: W] = tbl[t].av;
      b[tbl[t].idx*W +: W] = tbl[t].bv;
      req[tbl[t].idx] = 1'b1;
      wait_gnt("tbl", g);
      check("tbl gnt one-hot", 32'(g), 32'(1) << tbl[t].idx);
      req = '0;
      a = ~a;  // operands were captured at the grant edge
      b = ~b;
      lat_cnt  = 0;
      busy_cnt = 1;
      while (lat_cnt < 40) begin
        @(negedge clock);
        lat_cnt++;
        if (busy) busy_cnt++;
        if (res_valid) break;
      end
      check("tbl latency", 32'(lat_cnt), 32'(LAT));
      check("tbl res_data", 32'(res_data), 32'(tbl[t].exp));
      check("tbl res_id", 32'(res_id), 32'(tbl[t].idx));
      check("tbl busy cycles", 32'(busy_cnt), 32'(LAT + 1));
      @(negedge clock);
      check("tbl after {busy,rv}", 32'({busy, res_valid}), 32'b00);
      check("tbl res_data hold", 32'(res_data), 32'(tbl[t].exp));
    end

    // ---- all four held: grants 0,1,2,3,0 every LAT+1 cycles ----
    do_reset();
    a = $urandom;
    b = $urandom;
    req = '1;
    wait_gnt("rr", g);
    check("rr first grant", 32'(g), 32'b0001);
    for (int k = 1; k <= 4; k++) begin
      repeat (LAT) @(negedge clock);
      check("rr res_valid", 32'(res_valid), 32'd1);
      check("rr res_id", 32'(res_id), 32'((k - 1) % 4));
      @(negedge clock);
      check("rr grant", 32'(gnt), 32'(1) << (k % 4));
    end
    req = '0;
    wait_idle("rr");

    // ---- fairness after the pointer wraps: serve 3, then 0 beats 3 ----
    req[3] = 1'b1;
    wait_gnt("fair serve3", g);
    check("fair serve3 grant", 32'(g), 32'b1000);
    req = '0;
    wait_idle("fair serve3");
    req = 4'b1001;
    wait_gnt("fair contest", g);
    check("fair contest grant", 32'(g), 32'b0001);
    req[0] = 1'b0;
    wait_gnt("fair second", g);
    check("fair second grant", 32'(g), 32'b1000);
    req = '0;
    wait_idle("fair");

    // ---- withdrawal during another requester's WAIT ----
    req[2] = 1'b1;
    wait_gnt("wd serve2", g);
    check("wd serve2 grant", 32'(g), 32'b0100);
    req[2] = 1'b0;
    @(negedge clock);
    req[1] = 1'b1;
    repeat (3) @(negedge clock);
    req[1] = 1'b0;
    n_g1 = 0;
    g1_seen = 0;
    for (int c = 0; c < LAT + 5; c++) begin
      @(negedge clock);
      if (gnt[1]) g1_seen++;
      if (!busy) n_g1++;
    end
    check("wd no gnt[1]", 32'(g1_seen), 32'd0);
    check("wd returned idle", 32'(n_g1 > 0), 32'd1);

    // ---- reset mid-WAIT aborts; pointer restarts at 0 ----
    req[1] = 1'b1;
    wait_gnt("rst first", g);
    check("rst first grant", 32'(g), 32'b0010);
    req = '0;
    repeat (4) @(negedge clock);
    #2 reset_n = 1'b0;
    #1 check("rst outputs cleared", {16'h0, gnt, busy, res_valid, res_data, res_id}, 32'h0);
    repeat (2) @(negedge clock);
    #2 reset_n = 1'b1;
    req = 4'b1010;
    wait_gnt("rst regrant", g);
    check("rst regrant ptr0", 32'(g), 32'b0010);
    req[1] = 1'b0;
    wait_gnt("rst then3", g);
    check("rst then3 grant", 32'(g), 32'b1000);
    req = '0;
    wait_idle("rst");

    // ---- randomized requesters obeying the hold-until-grant rule ----
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          if (gnt[i] || $urandom_range(0, 39) == 0) req[i] = 1'b0;
        end else begin
          a[i*W +: W] = W'($urandom);
          b[i*W +: W] = W'($urandom);
          if ($urandom_range(0, 5) == 0) req[i] = 1'b1;
        end
      end
    end
    req = '0;
    wait_idle("random");
    @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/and_share_arbiter.md
# and_share_arbiter

Round-robin scheduler that shares one fixed-latency, delayed AND unit (result = a & b) between N_REQ requesters. It grants one request at a time, captures that requester's operands, and models the unit's delay as LAT clock cycles. It then returns the result tagged with the requester index. It sits between the requesting stimulus/datapath blocks and the shared delayed-AND resource, and is the only block that drives that resource.

## Interface
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 8, operand/result width in bits
- LAT, 10, unit latency in clock cycles (1..255)
- IDW, 2, result id width; must equal clog2(N_REQ)

- clock  input  1  rising-edge clock; the only clock
- reset_n  input  1  asynchronous, active-low reset
- req  input  N_REQ  per-requester request level
- a  input  N_REQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH]
- b  input  N_REQ*WIDTH  operand B; same packing as a
- gnt  output  N_REQ  one-hot, one-cycle grant pulse; operands are captured at the edge that raises it
- busy  output  1  high while an operation is in flight (ISSUE/WAIT/DONE)
- res_valid  output  1  one-cycle pulse; res_data/res_id are valid
- res_data  output  WIDTH  a & b of the granted requester
- res_id  output  IDW  index of the requester that produced res_data

## Operation
- Reset, asynchronous, active-low, applied immediately on reset_n low:
  - FSM goes to IDLE.
  - gnt = 0, busy = 0, res_valid = 0, res_data = 0, res_id = 0.
  - ptr = 0, cnt = 0.
- States:
  - IDLE: evaluate req each edge. If req == 0, stay. Otherwise select the winner, go to ISSUE, register gnt[winner] = 1, latch a_i & b_i into the result register, latch the id, and load cnt = LAT-1.
  - ISSUE, one cycle, gnt high: if cnt == 0, go to DONE; else go to WAIT.
  - WAIT: decrement cnt each edge; go to DONE when cnt reaches 0.
  - DONE, one cycle: res_valid = 1, ptr = id+1 mod N_REQ. Req is evaluated exactly as in IDLE, so DONE may go straight to ISSUE for the next winner; otherwise it goes to IDLE.
- Arbitration:
  - Winner is the first i with req[i] = 1, searching ptr, ptr+1, … mod N_REQ.
  - ptr changes only in DONE.
- Operand handling: only the AND result is stored. Operands are sampled once at the grant edge; later changes to a/b have no effect.
- Requester rule: hold req and operands until gnt is seen, then drop req at the next edge. Dropping req before grant withdraws the request; no grant is issued for it.
- Requests arriving while busy are held by the requester. They are never lost, and are considered at the DONE evaluation.
- res_data and res_id hold their values after the res_valid pulse until the next DONE.
- Width rules:
  - cnt is 8 bits.
  - ptr and id are IDW bits; the ptr increment wraps from N_REQ-1 to 0.
  - For non-power-of-two N_REQ, wrap explicitly.
- LAT = 1: no WAIT state; ISSUE → DONE.

## Timing
- Cycle G is the cycle in which gnt is high. It follows the edge that sampled req while in IDLE or DONE.
- res_valid is high in cycle G+LAT, with no other latency variation.
- Back-to-back:
  - The next gnt can be high in cycle G+LAT+1.
  - Sustained throughput is one operation per LAT+1 cycles.
- busy is high in cycles G through G+LAT and low in IDLE.
- Reset during ISSUE/WAIT/DONE aborts the operation:
  - No res_valid is produced for it.
  - The granted requester is not re-served; it must re-request.
- At most one gnt bit is high in any cycle. gnt and res_valid are never high in the same cycle, except that gnt is high in the cycle after a res_valid during back-to-back operation.

## Test plan
- Single request, LAT=10, WIDTH=8, req[2] with a=8'hF0, b=8'h3C → gnt = 4'b0100 for exactly one cycle; res_valid 10 cycles later with res_data = 8'h30, res_id = 2; busy high for 11 cycles.
- All four req held continuously, LAT=3 → grants in order 0,1,2,3,0 with period 4 cycles; each res_id matches its grant; no idle cycle between operations.
- Fairness after ptr move: serve req[3], then raise req[0] and req[3] together → req[0] wins (ptr = 0 after wrap).
- Withdrawal: raise req[1], then drop it during another requester's WAIT → no gnt[1] is ever issued; FSM returns to IDLE after DONE.
- Reset mid-WAIT, LAT=10: assert reset_n low 4 cycles after gnt → all outputs 0 immediately, no res_valid; after release, the same req is granted again with ptr = 0 priority.
- LAT=1 corner: req[0] held with a=8'hFF, b=8'hAA → gnt and res_valid alternate every cycle; res_data = 8'hAA; busy stays high.
